// File: rtl/wb_stage.sv
// Write-back stage: one pipeline register, load extraction, UART/counter MMIO
// window, and the register-file write port that also feeds forwarding.
module wb_stage #(
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  funct3_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [1:0]  control_wr_mux_i,
  input  logic [31:0] pc_plus_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_rx_valid_i,
  output logic        uart_rx_ready_o,
  output logic [7:0]  uart_tx_data_o,
  output logic        uart_tx_valid_o,
  input  logic        uart_tx_ready_i,
  output logic        stall_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_addr_o,
  output logic        wb_we_o
);

  localparam logic [7:0] OFF_STATUS  = 8'h00;
  localparam logic [7:0] OFF_RXDATA  = 8'h04;
  localparam logic [7:0] OFF_TXDATA  = 8'h08;
  localparam logic [7:0] OFF_CYCLE   = 8'h10;
  localparam logic [7:0] OFF_INSTRET = 8'h14;
  localparam logic [7:0] OFF_CLEAR   = 8'h18;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 valid_r;
  logic [31:0]          alu_r;
  logic [7:0]           store_r;
  logic [2:0]           funct3_r;
  logic                 mem_re_r;
  logic                 mem_we_r;
  logic [4:0]           wb_addr_r;
  logic [1:0]           sel_r;
  logic [31:0]          pc_plus_r;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] instret_cnt;
  logic [31:0]          cycle_word;
  logic [31:0]          instret_word;

  logic        mmio_hit;
  logic [7:0]  mmio_off;
  logic        tx_pending;
  logic        retire;
  logic        cnt_clear;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] dmem_data;
  logic [31:0] mmio_rdata;
  logic [31:0] load_data;
  logic        unused_store_bits;

  // Only the low byte of store data is ever consumed (UART TX).
  assign unused_store_bits = ^store_data_i[31:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r   <= 1'b0;
      alu_r     <= '0;
      store_r   <= '0;
      funct3_r  <= '0;
      mem_re_r  <= 1'b0;
      mem_we_r  <= 1'b0;
      wb_addr_r <= '0;
      sel_r     <= '0;
      pc_plus_r <= '0;
    end else if (!stall_o) begin
      valid_r   <= valid_i;
      alu_r     <= alu_result_i;
      store_r   <= store_data_i[7:0];
      funct3_r  <= funct3_i;
      mem_re_r  <= mem_re_i;
      mem_we_r  <= mem_we_i;
      wb_addr_r <= wb_addr_i;
      sel_r     <= control_wr_mux_i;
      pc_plus_r <= pc_plus_i;
    end
  end

  assign mmio_off   = alu_r[7:0];
  assign mmio_hit   = (mem_re_r | mem_we_r) && (alu_r[31:8] == MMIO_BASE[31:8]);
  assign tx_pending = valid_r && mem_we_r && mmio_hit && (mmio_off == OFF_TXDATA);
  assign stall_o    = tx_pending && !uart_tx_ready_i;
  assign retire     = valid_r && !stall_o;
  assign cnt_clear  = retire && mem_we_r && mmio_hit && (mmio_off == OFF_CLEAR);

  // Clear takes priority over the increment on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (cnt_clear) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      if (retire) instret_cnt <= instret_cnt + CNT_ONE;
    end
  end

  generate
    if (CNT_WIDTH >= 32) begin : g_cnt_wide
      assign cycle_word   = cycle_cnt[31:0];
      assign instret_word = instret_cnt[31:0];
    end else begin : g_cnt_narrow
      assign cycle_word   = {{(32-CNT_WIDTH){1'b0}}, cycle_cnt};
      assign instret_word = {{(32-CNT_WIDTH){1'b0}}, instret_cnt};
    end
  endgenerate

  always_comb begin
    load_byte = dmem_rdata_i[7:0];
    case (alu_r[1:0])
      2'd1:    load_byte = dmem_rdata_i[15:8];
      2'd2:    load_byte = dmem_rdata_i[23:16];
      2'd3:    load_byte = dmem_rdata_i[31:24];
      default: load_byte = dmem_rdata_i[7:0];
    endcase
    load_half = alu_r[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_r)
      3'b000:  dmem_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  dmem_data = {{16{load_half[15]}}, load_half};
      3'b100:  dmem_data = {24'b0, load_byte};
      3'b101:  dmem_data = {16'b0, load_half};
      default: dmem_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      OFF_STATUS:  mmio_rdata = {30'b0, uart_rx_valid_i, uart_tx_ready_i};
      OFF_RXDATA:  mmio_rdata = {24'b0, uart_rx_data_i};
      OFF_CYCLE:   mmio_rdata = cycle_word;
      OFF_INSTRET: mmio_rdata = instret_word;
      default:     mmio_rdata = '0;
    endcase
  end

  assign load_data = mmio_hit ? mmio_rdata : dmem_data;

  always_comb begin
    wb_data_o = alu_r;
    case (sel_r)
      2'b01:   wb_data_o = load_data;
      2'b10:   wb_data_o = pc_plus_r;
      default: wb_data_o = alu_r;
    endcase
  end

  assign wb_addr_o       = wb_addr_r;
  assign wb_we_o         = valid_r && (sel_r != 2'b11) && (wb_addr_r != 5'd0) && !stall_o;
  assign uart_rx_ready_o = valid_r && mem_re_r && mmio_hit && (mmio_off == OFF_RXDATA)
                           && uart_rx_valid_i;
  assign uart_tx_valid_o = tx_pending;
  assign uart_tx_data_o  = tx_pending ? store_r : 8'h00;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (memory-response/write-back) stage of the RISC-V core; consumes the execute stage's result bundle (ALU result, destination register, write-back mux select, PC+4).
- Holds one pipeline register of in-flight state.
- Extracts load data from synchronous DMEM, decodes the memory-mapped UART and counter registers, and drives the register-file write port.
- Its wb_data_o is the value forwarded back into execute.

Parameters:
MMIO_BASE, 32'h8000_0000, base address of the UART and counter register window
CNT_WIDTH, 32, width of the cycle and instret counters (wrap at 2^CNT_WIDTH)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_i  input  1  execute-stage bundle is a real instruction
alu_result_i  input  32  ALU result / memory address
store_data_i  input  32  rs2 value for stores
funct3_i  input  3  load/store width and sign code
mem_re_i  input  1  instruction is a load
mem_we_i  input  1  instruction is a store
wb_addr_i  input  5  destination register
control_wr_mux_i  input  2  write-back select: 00 ALU, 01 load/MMIO, 10 PC+4, 11 no write
pc_plus_i  input  32  PC+4 of the instruction
dmem_rdata_i  input  32  DMEM read word, valid the cycle after the address was presented
uart_rx_data_i  input  8  received byte
uart_rx_valid_i  input  1  receive byte available
uart_rx_ready_o  output  1  pop pulse for the receive byte
uart_tx_data_o  output  8  byte to transmit
uart_tx_valid_o  output  1  transmit request
uart_tx_ready_i  input  1  transmitter can accept a byte
stall_o  output  1  hold all upstream stages
wb_data_o  output  32  register-file write data / forwarding value
wb_addr_o  output  5  register-file write address
wb_we_o  output  1  register-file write enable

Behaviour:
- Reset (async, rst_n=0): all pipeline registers and valid_r clear to 0; both counters clear to 0.
- Outputs during reset: wb_we_o=0, wb_data_o=0, wb_addr_o=0, uart_tx_valid_o=0, uart_tx_data_o=0, uart_rx_ready_o=0, stall_o=0.
- Reset mid-handshake abandons the transmit with no retry.
- Capture: on each rising edge with stall_o=0, all inputs except dmem_rdata_i and the UART inputs register into the stage; valid_r<=valid_i. With stall_o=1 the registers hold.
- Latency: results appear one cycle after capture; all outputs are combinational from registered state plus dmem_rdata_i, uart_rx_*, uart_tx_ready_i.
- Load extraction, with a = alu_r[1:0]:
  - 000 LB: byte a, sign-extended.
  - 001 LH: half alu_r[1], sign-extended; alu_r[0] ignored.
  - 010 LW: full word; a ignored.
  - 100 LBU: byte a, zero-extended.
  - 101 LHU: half alu_r[1], zero-extended.
  - Other codes: full word.
- MMIO: a load/store with alu_r[31:8]==MMIO_BASE[31:8] bypasses DMEM data.
  - +0x00 read: {30'b0, uart_rx_valid_i, uart_tx_ready_i}.
  - +0x04 read: {24'b0, uart_rx_data_i}; uart_rx_ready_o=1 for that retiring cycle. Read with rx_valid=0 returns the current bus value, no pop, no stall.
  - +0x08 write: uart_tx_valid_o=1, uart_tx_data_o=store_r[7:0].
  - +0x10 read: cycle counter. +0x14 read: instret counter.
  - +0x18 write (any data): both counters become 0 on the next edge; clear beats increment.
  - Unmapped MMIO reads return 0; unmapped writes are ignored.
- Stall: stall_o=1 only while valid_r and a TX write is pending and uart_tx_ready_i=0. Valid/data stay stable until ready; the byte is accepted in the cycle ready=1.
- Upstream holds the DMEM address during stall, so dmem_rdata_i stays stable.
- Write-back select: 00 alu_r, 01 load/MMIO data, 10 pc_plus_r, 11 wb_data_o=alu_r with no write.
- wb_we_o = valid_r & (sel!=11) & (wb_addr_r!=0) & ~stall_o; wb_addr_o = wb_addr_r.
- Counters:
  - cycle increments every clock.
  - instret increments when valid_r & ~stall_o.
  - Both wrap to 0 at all-ones.
  - Reads return the pre-increment value.
  - A retiring counter-clear store still counts, but the clear wins.

Test Plan:
- LB/LBU at address 0x103 with dmem_rdata_i=0x80FF_7F01 -> wb_data_o 0xFFFF_FF80 and 0x0000_0080 respectively, wb_we_o=1.
- LH at 0x102 with rdata 0x8001_1234 -> 0xFFFF_8001; LHU at 0x100 -> 0x0000_1234; LW at 0x0 to x0 -> wb_we_o=0.
- TX store 0x41 to 0x8000_0008 with tx_ready low 3 cycles -> stall_o=1 for 3 cycles, tx_valid/data stable 0x41, single accept, then stall_o=0.
- RX load from 0x8000_0004 with rx_valid=1, data 0x5A -> wb_data_o 0x5A, uart_rx_ready_o one-cycle pulse; repeat with rx_valid=0 -> no pulse.
- Counters: 10 cycles with 6 valid retirements -> 0x10 reads 10, 0x14 reads 6; store to 0x18 -> both 0 next cycle; preload cycle=0xFFFF_FFFF -> wraps to 0.
- Assert rst_n low during TX stall -> all outputs 0 immediately, valid_r 0; release -> no spurious write or TX.
